// File: rtl/fpu_addsub_pkg.sv
// Shared types and constants for the sequential FPU adder-subtractor.
package fpu_addsub_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int EXP_W    = 8;
  localparam int EXP_W_DP = 11;

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit ripple adder cell; b arrives already inverted for subtract.
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);
  logic [CHUNK:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/addsub_seq_n.sv
// Multi-cycle adder-subtractor, CHUNK bits per clock, valid/ready on both sides.
// Define ADDSUB_SAT_EN to saturate the result on signed overflow.
module addsub_seq_n
  import fpu_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_e                    state_q;
  logic [N-1:0][CHUNK-1:0]   a_q, b_q, res_q, res_d;
  logic                      carry_q;
  logic [IDX_W-1:0]          idx_q;

  logic [CHUNK-1:0] sum_c;
  logic             cout_c, cmsb_c, ovf_c, a_msb;

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (a_q[idx_q]),
    .b        (b_q[idx_q]),
    .cin      (carry_q),
    .sum      (sum_c),
    .cout     (cout_c),
    .c_msb_in (cmsb_c)
  );

  assign a_msb    = a_q[N-1][CHUNK-1];
  assign ovf_c    = cmsb_c ^ cout_c;  // meaningful only on the last chunk
  assign in_ready = (state_q == IDLE) && !rst;

  always_comb begin
    res_d        = res_q;
    res_d[idx_q] = sum_c;
`ifdef ADDSUB_SAT_EN
    if (idx_q == LAST && ovf_c)
      res_d = {a_msb, {(WIDTH-1){~a_msb}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_cout   <= 1'b0;
      out_ovf    <= 1'b0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= in_a;
          b_q     <= in_b ^ {WIDTH{in_op}};
          carry_q <= in_op;
          idx_q   <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          res_q   <= res_d;
          carry_q <= cout_c;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            out_result <= res_d;
            out_cout   <= cout_c;
            out_ovf    <= ovf_c;
            out_zero   <= (res_d == '0);
            out_neg    <= res_d[N-1][CHUNK-1];
            out_valid  <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_seq_n.sv
// Directed-vector bench for addsub_seq_n at 8/4 and 24/8 configurations.
module tb_addsub_seq_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v8 = 0, r8, op8 = 0, ov8, ordy8 = 0, c8, o8, z8, n8;
  logic [7:0]  a8 = 0, b8 = 0, res8;
  logic        v24 = 0, r24, op24 = 0, ov24, ordy24 = 0, c24, o24, z24, n24;
  logic [23:0] a24 = 0, b24 = 0, res24;

  int vecs = 0;
  int errs = 0;

  addsub_seq_n #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8),
    .in_op(op8), .out_valid(ov8), .out_ready(ordy8), .out_result(res8),
    .out_cout(c8), .out_ovf(o8), .out_zero(z8), .out_neg(n8));

  addsub_seq_n #(.WIDTH(24), .CHUNK(8)) dut24 (
    .clk(clk), .rst(rst), .in_valid(v24), .in_ready(r24), .in_a(a24), .in_b(b24),
    .in_op(op24), .out_valid(ov24), .out_ready(ordy24), .out_result(res24),
    .out_cout(c24), .out_ovf(o24), .out_zero(z24), .out_neg(n24));

  // Issue one op, wait for out_valid, report latency in clocks after accept.
  // Result is left pending in DONE; caller pops it.
  task automatic issue(input bit wide, input logic [23:0] a, input logic [23:0] b,
                       input logic op, output int lat);
    @(negedge clk);
    if (wide) begin a24 = a; b24 = b; op24 = op; v24 = 1; end
    else      begin a8 = a[7:0]; b8 = b[7:0]; op8 = op; v8 = 1; end
    @(posedge clk);
    @(negedge clk);
    v8 = 0; v24 = 0;
    lat = 0;
    while (!(wide ? ov24 : ov8) && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    vecs++;
    if (!(wide ? ov24 : ov8)) begin
      errs++; $display("FAIL timeout waiting out_valid (wide=%0d)", wide);
    end
  endtask

  task automatic pop(input bit wide);
    @(negedge clk);
    if (wide) ordy24 = 1; else ordy8 = 1;
    @(negedge clk);
    ordy8 = 0; ordy24 = 0;
    vecs++;
    if ((wide ? ov24 : ov8) !== 1'b0) begin
      errs++; $display("FAIL pop out_valid got %b exp 0", wide ? ov24 : ov8);
    end
  endtask

  // Checks {result, cout, ovf, zero, neg} as one 12-bit value.
  task automatic op8chk(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic op, input logic [11:0] exp);
    int lat;
    issue(1'b0, {16'h0, a}, {16'h0, b}, op, lat);
    vecs++;
    if ({res8, c8, o8, z8, n8} !== exp) begin
      errs++; $display("FAIL %s got %h exp %h", nm, {res8, c8, o8, z8, n8}, exp);
    end
    vecs++;
    if (lat !== 2) begin
      errs++; $display("FAIL %s latency got %0d exp 2", nm, lat);
    end
    pop(1'b0);
  endtask

  task automatic op24chk(input string nm, input logic [23:0] a, input logic [23:0] b,
                         input logic op, input logic [27:0] exp);
    int lat;
    issue(1'b1, a, b, op, lat);
    vecs++;
    if ({res24, c24, o24, z24, n24} !== exp) begin
      errs++; $display("FAIL %s got %h exp %h", nm, {res24, c24, o24, z24, n24}, exp);
    end
    vecs++;
    if (lat !== 3) begin
      errs++; $display("FAIL %s latency got %0d exp 3", nm, lat);
    end
    pop(1'b1);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({ov8, r8, res8, c8, o8, z8, n8} !== 14'h0) begin
      errs++; $display("FAIL reset_outputs got %h exp 0", {ov8, r8, res8, c8, o8, z8, n8});
    end
    rst = 0;
    #1;
    vecs++;
    if ({r8, r24, ov24, res24} !== {2'b11, 25'h0}) begin
      errs++; $display("FAIL reset_release got %h exp %h", {r8, r24, ov24, res24}, {2'b11, 25'h0});
    end
  endtask

  task automatic test_narrow();
    op8chk("sub_20_05", 8'h20, 8'h05, 1'b1, {8'h1B, 4'b1000});
    op8chk("sub_05_20", 8'h05, 8'h20, 1'b1, {8'hE5, 4'b0001});
`ifdef ADDSUB_SAT_EN
    op8chk("add_7f_01", 8'h7F, 8'h01, 1'b0, {8'h7F, 4'b0100});
    op8chk("sub_80_01", 8'h80, 8'h01, 1'b1, {8'h80, 4'b1101});
`else
    op8chk("add_7f_01", 8'h7F, 8'h01, 1'b0, {8'h80, 4'b0101});
    op8chk("sub_80_01", 8'h80, 8'h01, 1'b1, {8'h7F, 4'b1100});
`endif
    op8chk("add_0f_01", 8'h0F, 8'h01, 1'b0, {8'h10, 4'b0000});
    op8chk("add_ff_01", 8'hFF, 8'h01, 1'b0, {8'h00, 4'b1010});
  endtask

  task automatic test_hold();
    int lat;
    issue(1'b0, 24'h3C, 24'h3C, 1'b1, lat);
    vecs++;
    if ({res8, c8, o8, z8, n8} !== {8'h00, 4'b1010}) begin
      errs++; $display("FAIL sub_3c_3c got %h exp %h", {res8, c8, o8, z8, n8}, {8'h00, 4'b1010});
    end
    a8 = 8'h11; b8 = 8'h22; op8 = 1'b0; v8 = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if ({ov8, r8, res8, c8, o8, z8, n8} !== {2'b10, 8'h00, 4'b1010}) begin
        errs++; $display("FAIL hold_cyc%0d got %h exp %h", i,
                         {ov8, r8, res8, c8, o8, z8, n8}, {2'b10, 8'h00, 4'b1010});
      end
    end
    v8 = 0;
    pop(1'b0);
    repeat (3) @(negedge clk);
    vecs++;
    if ({ov8, r8} !== 2'b01) begin
      errs++; $display("FAIL hold_no_accept got %b exp 01", {ov8, r8});
    end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; op8 = 1'b0; v8 = 1;
    @(posedge clk);
    @(negedge clk);
    v8 = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    vecs++;
    if ({ov8, r8, res8, c8, o8, z8, n8} !== {2'b01, 12'h0}) begin
      errs++; $display("FAIL rst_mid_busy got %h exp %h", {ov8, r8, res8, c8, o8, z8, n8}, {2'b01, 12'h0});
    end
    repeat (4) @(negedge clk);
    vecs++;
    if (ov8 !== 1'b0) begin
      errs++; $display("FAIL rst_abort_valid got %b exp 0", ov8);
    end
    op8chk("add_01_01", 8'h01, 8'h01, 1'b0, {8'h02, 4'b0000});
  endtask

  task automatic test_wide();
`ifdef ADDSUB_SAT_EN
    op24chk("w_sub_800000_1", 24'h800000, 24'h000001, 1'b1, {24'h800000, 4'b1101});
`else
    op24chk("w_sub_800000_1", 24'h800000, 24'h000001, 1'b1, {24'h7FFFFF, 4'b1100});
`endif
    op24chk("w_add_00ffff_1", 24'h00FFFF, 24'h000001, 1'b0, {24'h010000, 4'b0000});
    op24chk("w_sub_0_1",      24'h000000, 24'h000001, 1'b1, {24'hFFFFFF, 4'b0001});
  endtask

  initial begin
    test_reset();
    test_narrow();
    test_hold();
    test_reset_mid_busy();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
